// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx
//
// Serializer for the bsg_tag master bit stream. This is the transmit end of the
// tag network that configures the IO-link and clock-generator tag clients.
//
// After reset it sends init_ones_p ones and then gap_zeros_p zeros, which resets
// the remote tag master. After that it accepts one packet at a time through a
// valid/ready handshake. Each packet goes out one bit per cycle in this order:
//   start(1) | len (lg_w bits, LSB first) | data_not_reset | nodeid (lg_els bits,
//   LSB first) | payload (len bits, bit 0 first) | gap_zeros_p zeros
// clk_i also serves as the tag clock seen by the remote master.
//
// Ports:
//   clk_i            - single clock, also the tag clock
//   reset_i          - asynchronous, active-high reset
//   v_i              - packet request valid
//   nodeid_i         - destination client id
//   data_not_reset_i - 1 = data packet, 0 = client reset packet
//   len_i            - payload length in bits (saturates at max_payload_width_p)
//   payload_i        - payload, bit 0 sent first
//   ready_and_o      - request accepted this cycle when v_i is also high
//   tag_data_o       - registered serial tag data
//   init_done_o      - init sequence finished (sticky until reset)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// INIT_ONES   | sending the run of init ones after reset
// INIT_GAP    | sending the zeros that follow the init run
// IDLE        | line held at 0, ready for a request
// START       | start bit (1)
// LEN         | length field, LSB first
// DNR         | data_not_reset bit
// ID          | node id field, LSB first
// PAYLOAD     | payload bits, bit 0 first
// GAP         | trailing zeros after a packet

module bsg_tag_serial_tx #(
  parameter  int els_p               = 16,
  parameter  int max_payload_width_p = 8,
  parameter  int init_ones_p         = 8,
  parameter  int gap_zeros_p         = 4,
  localparam int lg_els_lp           = $clog2(els_p),
  localparam int lg_w_lp             = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [lg_els_lp-1:0]           nodeid_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_w_lp-1:0]             len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           ready_and_o,
  output logic                           tag_data_o,
  output logic                           init_done_o
);

  // Longest run the counter must time, and the width needed to hold it.
  localparam int run_a_lp     = (max_payload_width_p > init_ones_p) ? max_payload_width_p : init_ones_p;
  localparam int max_run_lp   = (run_a_lp > gap_zeros_p) ? run_a_lp : gap_zeros_p;
  localparam int hdr_w_lp     = (lg_w_lp > lg_els_lp) ? lg_w_lp : lg_els_lp;
  localparam int run_w_lp     = $clog2(max_run_lp) + 1;
  localparam int cnt_w_lp     = (hdr_w_lp > run_w_lp) ? hdr_w_lp : run_w_lp;

  // Reset leaves the counter at zero while already in INIT_ONES. Rather than
  // preloading it, the counter keeps decrementing through zero. The init run
  // ends when it reaches -(init_ones_p-1), modulo the counter width.
  localparam logic [cnt_w_lp-1:0] init_tc_lp =
    cnt_w_lp'(0) - cnt_w_lp'(init_ones_p - 1);

  localparam logic [lg_w_lp-1:0] max_len_lp = lg_w_lp'(max_payload_width_p);

  typedef enum logic [3:0] {
    S_INIT_ONES = 4'd0,
    S_INIT_GAP  = 4'd1,
    S_IDLE      = 4'd2,
    S_START     = 4'd3,
    S_LEN       = 4'd4,
    S_DNR       = 4'd5,
    S_ID        = 4'd6,
    S_PAYLOAD   = 4'd7,
    S_GAP       = 4'd8
  } state_e;

  state_e                         state_q, state_d;
  logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
  logic [lg_w_lp-1:0]             len_q, len_d;
  logic [lg_w_lp-1:0]             len_sh_q, len_sh_d;
  logic                           dnr_q, dnr_d;
  logic [lg_els_lp-1:0]           id_sh_q, id_sh_d;
  logic [max_payload_width_p-1:0] pay_sh_q, pay_sh_d;
  logic                           tag_data_q, tag_data_d;
  logic                           init_done_q, init_done_d;

  logic                           hs;
  logic                           cnt_tc;
  logic                           init_tc;
  logic [lg_w_lp-1:0]             len_sat;

  assign hs      = v_i & ready_and_o;
  assign cnt_tc  = (cnt_q == '0);
  assign init_tc = (cnt_q == init_tc_lp);
  assign len_sat = (len_i > max_len_lp) ? max_len_lp : len_i;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_INIT_ONES;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_ONES: if (init_tc) state_d = S_INIT_GAP;
      S_INIT_GAP:  if (cnt_tc)  state_d = S_IDLE;
      S_IDLE:      if (hs)      state_d = S_START;
      S_START:                  state_d = S_LEN;
      S_LEN:       if (cnt_tc)  state_d = S_DNR;
      S_DNR:                    state_d = S_ID;
      S_ID: begin
        if (cnt_tc) begin
          state_d = (len_q == '0) ? S_GAP : S_PAYLOAD;
        end
      end
      S_PAYLOAD:   if (cnt_tc)  state_d = S_GAP;
      S_GAP:       if (cnt_tc)  state_d = S_IDLE;
      default:                  state_d = S_INIT_ONES;
    endcase
  end

  // Output logic. The serial bit is the value for the current state. The
  // output flop presents it on the following cycle.
  always_comb begin
    tag_data_d  = 1'b0;
    ready_and_o = 1'b0;
    case (state_q)
      S_INIT_ONES: tag_data_d  = 1'b1;
      S_IDLE:      ready_and_o = 1'b1;
      S_START:     tag_data_d  = 1'b1;
      S_LEN:       tag_data_d  = len_sh_q[0];
      S_DNR:       tag_data_d  = dnr_q;
      S_ID:        tag_data_d  = id_sh_q[0];
      S_PAYLOAD:   tag_data_d  = pay_sh_q[0];
      default:     tag_data_d  = 1'b0;
    endcase
  end

  // Datapath: bit counter and holding/shift registers
  always_comb begin
    cnt_d       = cnt_q - cnt_w_lp'(1);
    len_d       = len_q;
    len_sh_d    = len_sh_q;
    dnr_d       = dnr_q;
    id_sh_d     = id_sh_q;
    pay_sh_d    = pay_sh_q;
    init_done_d = init_done_q | ((state_q == S_INIT_GAP) & cnt_tc);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hs) begin
          len_d    = len_sat;
          len_sh_d = len_sat;
          dnr_d    = data_not_reset_i;
          id_sh_d  = nodeid_i;
          pay_sh_d = payload_i;
        end
      end
      S_LEN:     len_sh_d = len_sh_q >> 1;
      S_ID:      id_sh_d  = id_sh_q >> 1;
      S_PAYLOAD: pay_sh_d = pay_sh_q >> 1;
      default: ;
    endcase

    // On entry to a timed state, load the counter with its bit count minus one.
    if (state_d != state_q) begin
      case (state_d)
        S_INIT_GAP: cnt_d = cnt_w_lp'(gap_zeros_p - 1);
        S_GAP:      cnt_d = cnt_w_lp'(gap_zeros_p - 1);
        S_LEN:      cnt_d = cnt_w_lp'(lg_w_lp - 1);
        S_ID:       cnt_d = cnt_w_lp'(lg_els_lp - 1);
        S_PAYLOAD:  cnt_d = cnt_w_lp'(len_q) - cnt_w_lp'(1);
        default:    cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      len_q       <= '0;
      len_sh_q    <= '0;
      dnr_q       <= 1'b0;
      id_sh_q     <= '0;
      pay_sh_q    <= '0;
      tag_data_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      len_sh_q    <= len_sh_d;
      dnr_q       <= dnr_d;
      id_sh_q     <= id_sh_d;
      pay_sh_q    <= pay_sh_d;
      tag_data_q  <= tag_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign tag_data_o  = tag_data_q;
  assign init_done_o = init_done_q;

  // An oversize length is saturated in hardware. This flags it in simulation.
  always @(posedge clk_i) begin
    if (!reset_i && hs) begin
      assert (len_i <= max_len_lp)
        else $warning("bsg_tag_serial_tx: len_i=%0d exceeds %0d, saturated",
                      len_i, max_payload_width_p);
    end
  end

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
module tb_bsg_tag_serial_tx;

  localparam int ELS    = 16;
  localparam int MAXW   = 8;
  localparam int INIT   = 8;
  localparam int GAP    = 4;
  localparam int LG_ELS = 4;
  localparam int LG_W   = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              v_i = 1'b0;
  logic [LG_ELS-1:0] nodeid_i = '0;
  logic              data_not_reset_i = 1'b0;
  logic [LG_W-1:0]   len_i = '0;
  logic [MAXW-1:0]   payload_i = '0;
  logic              ready_and_o;
  logic              tag_data_o;
  logic              init_done_o;

  bsg_tag_serial_tx #(
    .els_p(ELS), .max_payload_width_p(MAXW), .init_ones_p(INIT), .gap_zeros_p(GAP)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .nodeid_i(nodeid_i),
    .data_not_reset_i(data_not_reset_i), .len_i(len_i), .payload_i(payload_i),
    .ready_and_o(ready_and_o), .tag_data_o(tag_data_o), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // One entry per cycle of line activity:
  //   b    - bit belonging to that cycle (it appears on tag_data_o a cycle later)
  //   rdy  - expected ready in that cycle
  //   done - expected init_done in that cycle
  // An empty queue means the block is idle.
  typedef struct packed { bit b; bit rdy; bit done; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit last_bit = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  // Monitor: compares every cycle against the reference stream.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    cyc++;
    if (reset_i) begin
      chk("reset_tag", tag_data_o, 0);
      chk("reset_ready", ready_and_o, 0);
      chk("reset_init_done", init_done_o, 0);
      last_bit = 1'b0;
    end else begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '{b:1'b0, rdy:1'b1, done:1'b1};
      chk("tag_data", tag_data_o, 32'(last_bit));
      chk("ready", ready_and_o, 32'(e.rdy));
      chk("init_done", init_done_o, 32'(e.done));
      last_bit = e.b;
    end
  end

  // Reference model
  function automatic void push_bit(input bit b);
    exp_q.push_back('{b:b, rdy:1'b0, done:1'b1});
  endfunction

  function automatic void push_init();
    for (int i = 0; i < INIT; i++) exp_q.push_back('{b:1'b1, rdy:1'b0, done:1'b0});
    for (int i = 0; i < GAP; i++)  exp_q.push_back('{b:1'b0, rdy:1'b0, done:1'b0});
  endfunction

  function automatic void push_pkt(input int id, input int dnr, input int len, input int pay);
    int l;
    l = (len > MAXW) ? MAXW : len;
    exp_q.push_back('{b:1'b0, rdy:1'b1, done:1'b1});   // the handshake cycle itself
    push_bit(1'b1);
    for (int i = 0; i < LG_W; i++)   push_bit(bit'((l >> i) & 1));
    push_bit(bit'(dnr & 1));
    for (int i = 0; i < LG_ELS; i++) push_bit(bit'((id >> i) & 1));
    for (int i = 0; i < l; i++)      push_bit(bit'((pay >> i) & 1));
    for (int i = 0; i < GAP; i++)    push_bit(1'b0);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Call at posedge+1. The request is taken at the next edge only if the
  // model says the block is idle in this cycle.
  task automatic try_send(input bit v, input int id, input int dnr, input int len,
                          input int pay, output bit taken);
    v_i              = v;
    nodeid_i         = LG_ELS'(id);
    data_not_reset_i = 1'(dnr);
    len_i            = LG_W'(len);
    payload_i        = MAXW'(pay);
    taken = v && (exp_q.size() == 0);
    if (taken) push_pkt(id & 15, dnr & 1, len & 15, pay & 255);
  endtask

  task automatic send(input int id, input int dnr, input int len, input int pay);
    bit taken;
    int waited;
    taken  = 1'b0;
    waited = 0;
    while (!taken) begin
      step();
      if (waited > 200) begin
        chk("handshake_timeout", 1, 0);
        v_i = 1'b0;
        return;
      end
      try_send(1'b1, id, dnr, len, pay, taken);
      waited++;
    end
    step();
    v_i              = 1'b0;
    nodeid_i         = LG_ELS'($urandom);
    data_not_reset_i = 1'($urandom);
    len_i            = LG_W'($urandom);
    payload_i        = MAXW'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      step();
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    repeat (3) step();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit taken;
    int pk;
    int guard;

    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    push_init();
    reset_i = 1'b0;
    drain();
    repeat (5) step();

    // Directed packets
    send(5, 1, 3, 8'h05);
    send(2, 0, 0, int'($urandom));
    send(int'($urandom_range(0, 15)), 1, 15, 8'hFF);
    drain();

    // v_i held high while the fields change every cycle
    pk = 0;
    guard = 0;
    while (pk < 6 && guard < 400) begin
      step();
      try_send(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 9)), int'($urandom), taken);
      if (taken) pk++;
      guard++;
    end
    if (pk < 6) chk("held_valid_packets", 32'(pk), 6);
    step();
    v_i = 1'b0;
    drain();

    // Random traffic, including requests made while busy
    repeat (800) begin
      step();
      try_send($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom), taken);
    end
    v_i = 1'b0;
    drain();

    // Reset in the middle of the ID field
    send(15, 1, 5, 8'hAA);
    repeat (8) step();
    #1;
    chk("pre_reset_id_bit", tag_data_o, 1);
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    chk("async_reset_tag", tag_data_o, 0);
    chk("async_reset_ready", ready_and_o, 0);
    repeat (3) step();
    push_init();
    reset_i = 1'b0;
    drain();
    send(9, 1, 8, 8'h96);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
